// File: rtl/sosif_pkg.sv
// Shared SOSIF definitions: opcodes, sequencer states and command packing.
package sosif_pkg;

    typedef enum logic [7:0] {
        NOP  = 8'h00,
        HALT = 8'h01,
        PASS = 8'h02,
        FAIL = 8'h03,
        PUTC = 8'h10,
        INFO = 8'h11,
        WARN = 8'h12,
        ERR  = 8'h13,
        IRQ  = 8'h20
    } sosif_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_GAP
    } seq_state_e;

    // A flush or halt finishes the message being built, so it ends the lock.
    function automatic logic is_msg_end(input logic [7:0] op);
        return op inside {HALT, PASS, FAIL, INFO, WARN, ERR};
    endfunction

    // SOSIF word layout: opcode in the low byte, argument above it.
    function automatic logic [31:0] pack_cmd(input logic [7:0] op, input logic [15:0] arg);
        return {8'h00, arg, op};
    endfunction

endpackage

// File: rtl/sosif_sequencer_if.sv
// Requester handshake and Wishbone master bus of the SOSIF sequencer.
interface sosif_sequencer_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*8-1:0]  req_op_i;
    logic [NUM_REQ*16-1:0] req_arg_i;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [3:0]            wb_sel_o;
    logic [31:0]           wb_adr_o;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_i;

    // Sequencer side: takes requests, drives the Wishbone write.
    modport master (
        input  req_valid_i, req_op_i, req_arg_i, wb_ack_i,
        output req_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );

    // Environment side: requesters plus the SOSIF slave.
    modport slave (
        output req_valid_i, req_op_i, req_arg_i, wb_ack_i,
        input  req_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with optional eligibility mask and internal pointer.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req,
    input  logic          mask_en,
    input  logic [N-1:0]  mask,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index
);

    logic [IW-1:0] ptr;
    logic [N-1:0]  elig;
    logic          found;
    logic [IW-1:0] cand;
    int            j;

    // Scan eligible requests starting at the pointer and pick the first one.
    always_comb begin
        elig  = mask_en ? (req & mask) : req;
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            cand = IW'(j);
            if (!found && elig[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                index     = cand;
            end
        end
    end

    // After a grant the pointer moves just past the winner so everyone gets a turn.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (index == IW'(N - 1)) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/sosif_sequencer.sv
// Shares the SOSIF slave between requesters: arbitrates, holds a message
// lock while an agent is emitting characters, and issues one single-strobe
// Wishbone write per command with an ack timeout.
module sosif_sequencer
    import sosif_pkg::*;
#(
    parameter  int          NUM_REQ   = 4,
    parameter  logic [31:0] BASE_ADDR = 32'h0,
    parameter  int          TIMEOUT   = 64,
    localparam int          OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int          CW        = $clog2(TIMEOUT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sosif_sequencer_if.master bus,
    output logic              busy_o,
    output logic              locked_o,
    output logic [OW-1:0]     owner_o,
    output logic              err_o
);

    seq_state_e   state_q, state_d;
    logic [31:0]  cmd_q, cmd_d;
    logic         lock_q, lock_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] owner_mask;
    logic [OW-1:0]      gidx;
    logic               grant;
    logic [7:0]         sel_op;
    logic [15:0]        sel_arg;

    assign owner_mask = NUM_REQ'(1) << owner_q;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (bus.req_valid_i),
        .mask_en (lock_q),
        .mask    (owner_mask),
        .advance (grant),
        .gnt     (gnt),
        .index   (gidx)
    );

    assign grant = (state_q == ST_IDLE) && !rst_i && (|gnt);

    assign bus.wb_we_o  = 1'b1;
    assign bus.wb_sel_o = 4'b1111;
    assign bus.wb_adr_o = BASE_ADDR;
    assign bus.wb_dat_o = cmd_q;
    assign locked_o     = lock_q;

    // Pick out the opcode and argument of whichever requester won arbitration.
    always_comb begin
        sel_op  = '0;
        sel_arg = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gidx == OW'(k)) begin
                sel_op  = bus.req_op_i[8*k +: 8];
                sel_arg = bus.req_arg_i[16*k +: 16];
            end
        end
    end

    // Next-state and outputs: accept, one strobe cycle, wait for ack or timeout, then a cyc-low gap.
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        lock_d          = lock_q;
        owner_d         = owner_q;
        cnt_d           = '0;
        owner_o         = owner_q;
        bus.req_ready_o = '0;
        bus.wb_cyc_o    = 1'b0;
        bus.wb_stb_o    = 1'b0;
        busy_o          = 1'b0;
        err_o           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    bus.req_ready_o = gnt;
                    cmd_d           = pack_cmd(sel_op, sel_arg);
                    owner_d         = gidx;
                    owner_o         = gidx;
                    if (sel_op == PUTC) begin
                        lock_d = 1'b1;
                    end
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                bus.wb_cyc_o = 1'b1;
                bus.wb_stb_o = 1'b1;
                busy_o       = 1'b1;
                cnt_d        = cnt_q + 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                bus.wb_cyc_o = 1'b1;
                busy_o       = 1'b1;
                if (bus.wb_ack_i) begin
                    if (is_msg_end(cmd_q[7:0])) begin
                        lock_d = 1'b0;
                    end
                    state_d = ST_GAP;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    err_o   = !rst_i;
                    lock_d  = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight write without reporting it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            lock_q  <= 1'b0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sosif_sequencer.sv
// Directed bench for sosif_sequencer: message building, arbitration,
// locking, IRQ forwarding, ack timeout and reset during a write.
module tb_sosif_sequencer;
    import sosif_pkg::*;

    localparam int          NREQ = 4;
    localparam logic [31:0] BASE = 32'hA000_0100;
    localparam int          TMO  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic       locked;
    logic       err;
    logic [1:0] owner;
    int         compared   = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    sosif_sequencer_if #(.NUM_REQ(NREQ)) bus ();

    sosif_sequencer #(
        .NUM_REQ  (NREQ),
        .BASE_ADDR(BASE),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .busy_o  (busy),
        .locked_o(locked),
        .owner_o (owner),
        .err_o   (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic valid, input logic [7:0] op, input logic [15:0] arg);
        bus.req_valid_i[k]         = valid;
        bus.req_op_i[8*k +: 8]     = op;
        bus.req_arg_i[16*k +: 16]  = arg;
    endtask

    // Runs one complete write starting in an IDLE cycle with the request already set up.
    task automatic transact(input string tag, input logic [3:0] expReady, input logic [1:0] expOwner,
                            input logic [31:0] expDat, input logic expLockDuring,
                            input logic expLockAfter, input logic dropValid);
        #1;
        checkOutput({tag, " ready"}, 32'(bus.req_ready_o), 32'(expReady));
        checkOutput({tag, " owner"}, 32'(owner), 32'(expOwner));
        step();
        if (dropValid) bus.req_valid_i = bus.req_valid_i & ~expReady;
        #1;
        checkOutput({tag, " stb"}, 32'(bus.wb_stb_o), 32'd1);
        checkOutput({tag, " cyc"}, 32'(bus.wb_cyc_o), 32'd1);
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " dat"}, bus.wb_dat_o, expDat);
        checkOutput({tag, " lock"}, 32'(locked), 32'(expLockDuring));
        checkOutput({tag, " ready idle"}, 32'(bus.req_ready_o), 32'd0);
        step();
        checkOutput({tag, " wait stb"}, 32'(bus.wb_stb_o), 32'd0);
        checkOutput({tag, " wait cyc"}, 32'(bus.wb_cyc_o), 32'd1);
        bus.wb_ack_i = 1'b1;
        #1;
        checkOutput({tag, " err"}, 32'(err), 32'd0);
        step();
        bus.wb_ack_i = 1'b0;
        #1;
        checkOutput({tag, " gap cyc"}, 32'(bus.wb_cyc_o), 32'd0);
        checkOutput({tag, " gap lock"}, 32'(locked), 32'(expLockAfter));
        checkOutput({tag, " gap ready"}, 32'(bus.req_ready_o), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.req_valid_i = '0;
        bus.req_op_i    = '0;
        bus.req_arg_i   = '0;
        bus.wb_ack_i    = 1'b0;

        // Reset values
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst cyc", 32'(bus.wb_cyc_o), 32'd0);
        checkOutput("rst stb", 32'(bus.wb_stb_o), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst lock", 32'(locked), 32'd0);
        checkOutput("rst owner", 32'(owner), 32'd0);
        checkOutput("rst err", 32'(err), 32'd0);
        checkOutput("rst dat", bus.wb_dat_o, 32'd0);
        checkOutput("rst we", 32'(bus.wb_we_o), 32'd1);
        checkOutput("rst sel", 32'(bus.wb_sel_o), 32'hF);
        checkOutput("rst adr", bus.wb_adr_o, BASE);

        // Single requester writes "Hi" then flushes
        $display("[TB] message from requester 0");
        applyStimulus(0, 1'b1, PUTC, 16'h0048);
        transact("putc H", 4'b0001, 2'd0, 32'h0000_4810, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, PUTC, 16'h0069);
        transact("putc i", 4'b0001, 2'd0, 32'h0000_6910, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, INFO, 16'h0000);
        transact("info", 4'b0001, 2'd0, 32'h0000_0011, 1'b1, 1'b0, 1'b1);

        // Requesters 0 and 2 hold NOP continuously after a fresh reset
        $display("[TB] round robin 0/2");
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(0, 1'b1, NOP, 16'h0000);
        applyStimulus(2, 1'b1, NOP, 16'h0000);
        transact("rr0 a", 4'b0001, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        transact("rr2 a", 4'b0100, 2'd2, 32'h0, 1'b0, 1'b0, 1'b0);
        transact("rr0 b", 4'b0001, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        transact("rr2 b", 4'b0100, 2'd2, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, NOP, 16'h0000);
        applyStimulus(2, 1'b0, NOP, 16'h0000);

        // Requester 1 builds a message while requester 0 waits
        $display("[TB] lock held by requester 1");
        applyStimulus(1, 1'b1, PUTC, 16'h0041);
        transact("lock A", 4'b0010, 2'd1, 32'h0000_4110, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, NOP, 16'h0000);
        #1;
        checkOutput("stall ready a", 32'(bus.req_ready_o), 32'd0);
        checkOutput("stall lock", 32'(locked), 32'd1);
        step();
        checkOutput("stall ready b", 32'(bus.req_ready_o), 32'd0);
        applyStimulus(1, 1'b1, PUTC, 16'h0042);
        transact("lock B", 4'b0010, 2'd1, 32'h0000_4210, 1'b1, 1'b1, 1'b1);
        applyStimulus(1, 1'b1, INFO, 16'h0000);
        transact("lock info", 4'b0010, 2'd1, 32'h0000_0011, 1'b1, 1'b0, 1'b1);
        transact("waiter", 4'b0001, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // IRQ and an unknown opcode from requester 3
        $display("[TB] irq and unknown op");
        applyStimulus(3, 1'b1, IRQ, 16'hBEEF);
        transact("irq", 4'b1000, 2'd3, 32'h00BE_EF20, 1'b0, 1'b0, 1'b1);
        applyStimulus(3, 1'b1, 8'h7E, 16'h1234);
        transact("unknown", 4'b1000, 2'd3, 32'h0012_347E, 1'b0, 1'b0, 1'b1);

        // Slave never acks a PUTC from requester 2
        $display("[TB] ack timeout");
        applyStimulus(2, 1'b1, PUTC, 16'h005A);
        #1;
        checkOutput("tmo ready", 32'(bus.req_ready_o), 32'b0100);
        step();
        applyStimulus(2, 1'b0, PUTC, 16'h005A);
        applyStimulus(0, 1'b1, NOP, 16'h0000);
        #1;
        checkOutput("tmo stb", 32'(bus.wb_stb_o), 32'd1);
        checkOutput("tmo lock", 32'(locked), 32'd1);
        for (int k = 1; k < TMO; k++) begin
            step();
            checkOutput($sformatf("tmo wait err %0d", k), 32'(err), 32'd0);
            checkOutput($sformatf("tmo wait cyc %0d", k), 32'(bus.wb_cyc_o), 32'd1);
            checkOutput($sformatf("tmo wait ready %0d", k), 32'(bus.req_ready_o), 32'd0);
        end
        step();
        checkOutput("tmo err pulse", 32'(err), 32'd1);
        step();
        bus.wb_ack_i = 1'b1;
        #1;
        checkOutput("tmo err end", 32'(err), 32'd0);
        checkOutput("tmo cyc drop", 32'(bus.wb_cyc_o), 32'd0);
        checkOutput("tmo unlock", 32'(locked), 32'd0);
        step();
        bus.wb_ack_i = 1'b0;
        transact("after tmo", 4'b0001, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset while requester 1 is mid-write and holds the lock
        $display("[TB] reset during wait");
        applyStimulus(1, 1'b1, PUTC, 16'h0051);
        #1;
        checkOutput("rw ready", 32'(bus.req_ready_o), 32'b0010);
        step();
        applyStimulus(1, 1'b0, PUTC, 16'h0051);
        #1;
        checkOutput("rw lock", 32'(locked), 32'd1);
        step();
        rst = 1'b1;
        step();
        checkOutput("rw cyc", 32'(bus.wb_cyc_o), 32'd0);
        checkOutput("rw stb", 32'(bus.wb_stb_o), 32'd0);
        checkOutput("rw lock clr", 32'(locked), 32'd0);
        checkOutput("rw busy", 32'(busy), 32'd0);
        checkOutput("rw err", 32'(err), 32'd0);
        rst = 1'b0;
        applyStimulus(0, 1'b1, NOP, 16'h0000);
        applyStimulus(2, 1'b1, NOP, 16'h0000);
        transact("rw regrant", 4'b0001, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2, 1'b0, NOP, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
